// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART TX arbiter.
// Holds the FSM state enum, default timeouts and port indices.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    HOLD      = 2'd2
  } arb_state_e;

  localparam int unsigned TX_TIMEOUT_DEF  = 20_000;
  localparam int unsigned GAP_TIMEOUT_DEF = 5_000_000;

  localparam int PORT_FFT = 0;
  localparam int PORT_RPT = 1;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
// Ports: req_i[1:0], last_served_i -> one-hot pick_o[1:0].
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_served_i,
  output logic [1:0] pick_o
);

  always_comb begin
    pick_o = 2'b00;
    unique case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      // tie: the port not served last wins
      2'b11:   pick_o = last_served_i ? 2'b01 : 2'b10;
      default: pick_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-level 2:1 arbiter sharing uart_top.
// Ports: req/data/last/ack per port, uart_tx_* to uart_top, grant/busy/abort.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned TX_TIMEOUT  = TX_TIMEOUT_DEF,
  parameter int unsigned GAP_TIMEOUT = GAP_TIMEOUT_DEF
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [7:0] data0,
  input  logic       last0,
  input  logic       req1,
  input  logic [7:0] data1,
  input  logic       last1,
  output logic       ack0,
  output logic       ack1,
  output logic       uart_tx_en,
  output logic [7:0] uart_tx_data,
  input  logic       uart_tx_done,
  output logic [1:0] grant,
  output logic       busy,
  output logic       abort
);

  localparam int unsigned CMAX =
    max2(TX_TIMEOUT, GAP_TIMEOUT);
  localparam int unsigned CW = $clog2(CMAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t TX_LIM  = cnt_t'(TX_TIMEOUT);
  localparam cnt_t GAP_LIM = cnt_t'(GAP_TIMEOUT);
  localparam cnt_t C_MAX   = cnt_t'(CMAX);

  arb_state_e state_q, state_d;
  // owner: 0 = FFT port, 1 = report port
  logic       owner_q, owner_d;
  logic       last_q, last_d;
  logic       ls_q, ls_d;
  cnt_t       cnt_q, cnt_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] ack_q, ack_d;
  logic       en_q, en_d;
  logic       abort_q, abort_d;
  logic       busy_q;
  logic [7:0] data_q, data_d;

  logic [1:0] req_v;
  logic [1:0] pick;
  logic       load;
  logic       load_port;

  always_comb begin
    req_v = 2'b00;
    req_v[PORT_FFT] = req0;
    req_v[PORT_RPT] = req1;
  end

  rr_pick2 u_pick (
    .req_i         (req_v),
    .last_served_i (ls_q),
    .pick_o        (pick)
  );

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    ls_d      = ls_q;
    grant_d   = grant_q;
    data_d    = data_q;
    ack_d     = 2'b00;
    en_d      = 1'b0;
    abort_d   = 1'b0;
    load      = 1'b0;
    load_port = owner_q;
    // saturating count; never wraps
    cnt_d = (cnt_q >= C_MAX) ? cnt_q
                             : cnt_q + cnt_t'(1);

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick != 2'b00) begin
          load      = 1'b1;
          load_port = pick[1];
        end
      end
      WAIT_DONE: begin
        if (uart_tx_done) begin
          if (last_q) begin
            state_d = IDLE;
            ls_d    = owner_q;
            grant_d = 2'b00;
          end else begin
            state_d = HOLD;
            cnt_d   = '0;
          end
        end else if (cnt_q >= TX_LIM) begin
          abort_d = 1'b1;
          state_d = IDLE;
          ls_d    = owner_q;
          grant_d = 2'b00;
        end
      end
      HOLD: begin
        if (req_v[owner_q]) begin
          load      = 1'b1;
          load_port = owner_q;
        end else if (cnt_q >= GAP_LIM) begin
          abort_d = 1'b1;
          state_d = IDLE;
          ls_d    = owner_q;
          grant_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d          = WAIT_DONE;
      owner_d          = load_port;
      data_d           = load_port ? data1 : data0;
      last_d           = load_port ? last1 : last0;
      en_d             = 1'b1;
      ack_d[load_port] = 1'b1;
      grant_d          = load_port ? 2'b10 : 2'b01;
      cnt_d            = '0;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
      ls_q    <= 1'b1;
      cnt_q   <= '0;
      grant_q <= 2'b00;
      ack_q   <= 2'b00;
      en_q    <= 1'b0;
      abort_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      ls_q    <= ls_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      abort_q <= abort_d;
      busy_q  <= (state_d != IDLE);
      data_q  <= data_d;
    end
  end

  assign ack0         = ack_q[0];
  assign ack1         = ack_q[1];
  assign uart_tx_en   = en_q;
  assign uart_tx_data = data_q;
  assign grant        = grant_q;
  assign busy         = busy_q;
  assign abort        = abort_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Frame-level arbiter that shares the single `uart_top` transmitter between two byte-stream requesters: port 0 is the FFT spectrum stream and port 1 is the measurement/report stream. A requester owns the UART for a whole frame, from its first byte through the byte marked `last`, so frames never interleave. Ties between ports are resolved round-robin. The block sits between the packet formatters and `uart_top` in the `sys_clk` domain. It also guards against a stalled transmitter and against an owner that stalls mid-frame.

## Interface
Parameters:
- `TX_TIMEOUT`, 20_000: max `sys_clk` cycles from `uart_tx_en` to `uart_tx_done` before the frame is aborted (≈4.6 bytes at 115200 baud, 50 MHz).
- `GAP_TIMEOUT`, 5_000_000: max idle cycles the owner may leave between bytes of one frame (100 ms).

Ports:
- `sys_clk` input 1: system clock, 50 MHz.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` / `req1` input 1: byte valid from port 0/1; held with data/last until ack.
- `data0` / `data1` input 8: byte to send.
- `last0` / `last1` input 1: byte is the final byte of its frame.
- `ack0` / `ack1` output 1: one-cycle pulse; byte accepted, requester may advance.
- `uart_tx_en` output 1: one-cycle start pulse to `uart_top`.
- `uart_tx_data` output 8: byte to `uart_top`, held stable until the next load.
- `uart_tx_done` input 1: one-cycle pulse from `uart_top`, byte finished.
- `grant` output 2: one-hot current frame owner; `2'b00` when free.
- `busy` output 1: high in every state except IDLE.
- `abort` output 1: one-cycle pulse when a frame is aborted by either timeout.

## Operation
- States:
  - IDLE: no owner.
  - WAIT_DONE: byte in flight.
  - HOLD: owner mid-frame, waiting for its next byte.
- IDLE:
  - If only one `reqN` is high, that port wins.
  - If both are high, the port not served last wins. The `last_served` register resets to 1, so port 0 wins the first tie.
  - On winning: load the winner's byte, then go to WAIT_DONE.
- Load action (from IDLE or HOLD), all taken at the same edge:
  - `uart_tx_data` ← `dataN`.
  - `uart_tx_en` ← 1 and `ackN` ← 1, each for one cycle.
  - `grant` ← owner.
  - `last_q` ← `lastN`.
  - Timeout counter cleared.
- WAIT_DONE:
  - Counts cycles. The non-owner's request is ignored.
  - On `uart_tx_done`: if `last_q` is set, go to IDLE, set `last_served` ← owner and clear `grant`; otherwise go to HOLD with the gap counter cleared.
  - If the count reaches `TX_TIMEOUT` before `uart_tx_done`: pulse `abort`, go to IDLE, update `last_served`.
- HOLD:
  - On owner `reqN`: load the byte, go to WAIT_DONE. The other port's `req` is ignored.
  - If the gap count reaches `GAP_TIMEOUT`: pulse `abort`, go to IDLE, update `last_served`.
- `uart_tx_done` received in IDLE or HOLD is ignored.
- A single-byte frame (`last` set on the first byte) returns to IDLE directly from WAIT_DONE.
- `lastN` from a non-owner is never sampled.
- Counters are sized to the larger of the two timeouts and saturate at it; they never wrap.
- Reset at any time returns the block to IDLE:
  - All outputs 0, including `uart_tx_data` = 8'h00.
  - `last_served` = 1.
  - Any in-flight byte is abandoned; its later `uart_tx_done` is ignored.

## Timing
- All outputs are registered.
- `req` sampled high at edge k (in IDLE or HOLD) → `uart_tx_en`, `ackN` and `grant` high in cycle k+1.
- Requester rule: drive the next byte in cycle k+2 at the earliest. Requests are not sampled in WAIT_DONE, so a held `req` cannot double-send.
- `uart_tx_done` at edge m, non-last byte → HOLD from m+1; a held `req` loads at m+1, so `uart_tx_en` is high in cycle m+2.
- `uart_tx_done` at edge m, last byte → `grant` is 0 in cycle m+1. The next frame's `uart_tx_en` comes at the earliest in cycle m+2.
- Timeout: `abort` is high in the cycle after the counter reaches its limit, and `grant` is 0 in that same cycle.
- Pulses (`ack`, `uart_tx_en`, `abort`) are exactly one cycle wide.

## Structure
- Package `uart_arb_pkg`:
  - State enum (IDLE, WAIT_DONE, HOLD).
  - Default timeout constants.
  - Port index constants (`PORT_FFT` = 0, `PORT_RPT` = 1).
- Sub-module `rr_pick2`: combinational two-way round-robin picker (`req[1:0]`, `last_served` → one-hot `pick`). This is the natural unit for widening to more ports later.
- Top FSM, counters and output registers live in `uart_tx_arbiter`.

## Test plan
- Port 0 three-byte frame A1,A2,A3 with `last` on A3; `uart_tx_done` 100 cycles after each `uart_tx_en` → `uart_tx_data` sequence A1,A2,A3; three `ack0` pulses; `grant`=01 throughout, 00 after the third done.
- Both ports request in the same cycle from reset, single-byte frames 11 (port 0) and 22 (port 1), repeated → service order 11,22,11,22; `grant` alternates 01,10.
- Port 1 requests while port 0 sits in HOLD mid-frame → no `ack1` and no port-1 byte until port 0's `last` byte completes; then port 1 sent within 2 cycles.
- `uart_tx_done` withheld with `TX_TIMEOUT`=50 → `abort` one cycle about 51 cycles after `uart_tx_en`; block returns to IDLE; a subsequent `uart_tx_done` pulse is ignored.
- Owner stalls in HOLD with `GAP_TIMEOUT`=30 → `abort` pulse, `grant`=00, the other port served next.
- `rst_n` asserted during WAIT_DONE → all outputs 0 immediately; after release a port-0 request is granted first.
